rr_mem_arbiter: RTL and testbench

Parametrised round-robin arbiter with an integrated single-port word memory, the next generation of the three-requester arbiter. N requesters compete for the memory through per-channel valid/ready handshakes. A granted owner may keep the port for a bounded burst of back-to-back transfers. Registered read data is steered back to the requesting channel. The block sits between the requester instances and shared storage in the top level.

---
 rtl/arb_pkg.sv | 15 +
 rtl/rr_picker.sv | 34 +++
 rtl/rr_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_rr_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the round-robin memory arbiter.
// Provides the FSM state enum and an index-width helper.
package arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_e;

   // Width of an index into n items; never below one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating priority encoder: first set req bit at or after ptr, mod N.
// Ports: req (N), ptr (index) -> any (hit), idx (winner index).
module rr_picker
   import arb_pkg::*;
#(
   parameter int N  = 3,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [IW-1:0] idx
);

   int          j;
   logic [IW-1:0] c;

   // Scan from the farthest offset down so the nearest hit wins.
   always_comb begin
      any = 1'b0;
      idx = '0;
      j   = 0;
      c   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N;
         c = IW'(j);
         if (req[c]) begin
            any = 1'b1;
            idx = c;
         end
      end
   end

endmodule

// File: rtl/rr_mem_arbiter.sv
// Round-robin arbiter in front of a single-port word memory.
// Ports: per-channel req_valid/rw/addr/wdata in, req_ready/rsp_valid out,
// shared rsp_rdata, grant_id (owner) and busy (state OWN).
module rr_mem_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_REQUESTERS = 3,
   parameter int DATA_WIDTH     = 4,
   parameter int DEPTH          = 16,
   parameter int MAX_BURST      = 2
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [NUM_REQUESTERS-1:0]                  req_valid,
   input  logic [NUM_REQUESTERS-1:0]                  req_rw,
   input  logic [NUM_REQUESTERS*$clog2(DEPTH)-1:0]    req_addr,
   input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]       req_wdata,
   output logic [NUM_REQUESTERS-1:0]                  req_ready,
   output logic [NUM_REQUESTERS-1:0]                  rsp_valid,
   output logic [DATA_WIDTH-1:0]                      rsp_rdata,
   output logic [idx_w(NUM_REQUESTERS)-1:0]           grant_id,
   output logic                                       busy
);

   localparam int N  = NUM_REQUESTERS;
   localparam int DW = DATA_WIDTH;
   localparam int AW = $clog2(DEPTH);
   localparam int IW = idx_w(N);
   localparam int BW = idx_w(MAX_BURST);

   localparam logic [IW-1:0] LAST  = IW'(N - 1);
   localparam logic [BW-1:0] BLAST = BW'(MAX_BURST - 1);

   state_e          state_q;
   logic [IW-1:0]   owner_q;
   logic [IW-1:0]   rr_ptr_q;
   logic [BW-1:0]   beat_q;
   logic [N-1:0]    rsp_valid_q;
   logic [DW-1:0]   rsp_rdata_q;
   logic [DW-1:0]   mem_q [DEPTH];

   logic            own;
   logic [N-1:0]    own_oh;
   logic            own_valid;
   logic            own_rd;
   logic            xfer;
   logic            rel;
   logic [AW-1:0]   own_addr;
   logic [DW-1:0]   own_wdata;
   logic [IW-1:0]   nxt_owner;
   logic [IW-1:0]   pick_ptr;
   logic            pick_any;
   logic [IW-1:0]   pick_idx;

   // Steer the owner's address and write data onto the memory port.
   always_comb begin
      own_addr  = '0;
      own_wdata = '0;
      for (int i = 0; i < N; i++) begin
         if (owner_q == IW'(i)) begin
            own_addr  = req_addr[i*AW +: AW];
            own_wdata = req_wdata[i*DW +: DW];
         end
      end
   end

   assign own       = (state_q == OWN);
   assign own_oh    = N'(1) << owner_q;
   assign own_valid = req_valid[owner_q];
   assign own_rd    = req_rw[owner_q];
   assign xfer      = own & own_valid;
   assign nxt_owner = (owner_q == LAST) ? '0 : owner_q + 1'b1;

   // Release on a dropped valid or on the last beat of a burst.
   assign rel = own & (~own_valid | (beat_q == BLAST));

   // On release the old owner becomes lowest priority immediately.
   assign pick_ptr = rel ? nxt_owner : rr_ptr_q;

   rr_picker #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req (req_valid),
      .ptr (pick_ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         beat_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pick_any) begin
                  owner_q <= pick_idx;
                  beat_q  <= '0;
                  state_q <= OWN;
               end
            end
            OWN: begin
               if (rel) begin
                  rr_ptr_q <= nxt_owner;
                  beat_q   <= '0;
                  if (pick_any) begin
                     owner_q <= pick_idx;
                  end else begin
                     state_q <= IDLE;
                  end
               end else if (xfer) begin
                  beat_q <= beat_q + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= (xfer & own_rd) ? own_oh : '0;
         if (xfer & own_rd) begin
            rsp_rdata_q <= mem_q[own_addr];
         end
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (xfer & ~own_rd) begin
         mem_q[own_addr] <= own_wdata;
      end
   end

   assign req_ready = own ? own_oh : '0;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign grant_id  = owner_q;
   assign busy      = own;

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Directed self-checking bench for rr_mem_arbiter.
// Configuration: N=3, DW=4, DEPTH=16, MAX_BURST=2.
module tb_rr_mem_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  req_valid;
   logic [2:0]  req_rw;
   logic [11:0] req_addr;
   logic [11:0] req_wdata;
   logic [2:0]  req_ready;
   logic [2:0]  rsp_valid;
   logic [3:0]  rsp_rdata;
   logic [1:0]  grant_id;
   logic        busy;

   int ntot;
   int nbad;

   rr_mem_arbiter #(
      .NUM_REQUESTERS (3),
      .DATA_WIDTH     (4),
      .DEPTH          (16),
      .MAX_BURST      (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_rw    (req_rw),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      ntot++;
      if ({req_ready, rsp_valid, rsp_rdata, grant_id, busy} !== 13'd0) begin
         $display("FAIL reset_outs got=%h want=0",
                  {req_ready, rsp_valid, rsp_rdata, grant_id, busy});
         nbad++;
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_write();
      req_valid = 3'b010;
      req_rw    = 3'b000;
      req_addr[4 +: 4]  = 4'd5;
      req_wdata[4 +: 4] = 4'hA;
      tick();
      ntot++;
      if (req_ready !== 3'b010 || grant_id !== 2'd1 || busy !== 1'b1) begin
         $display("FAIL wr_grant got=%b/%0d/%b want=010/1/1",
                  req_ready, grant_id, busy);
         nbad++;
      end
      tick();
      req_valid = 3'b000;
      tick();
      ntot++;
      if (busy !== 1'b0 || req_ready !== 3'b000) begin
         $display("FAIL wr_release got=%b/%b want=0/000", busy, req_ready);
         nbad++;
      end
   endtask

   task automatic test_read();
      req_valid = 3'b001;
      req_rw    = 3'b001;
      req_addr[0 +: 4] = 4'd5;
      tick();
      ntot++;
      if (req_ready !== 3'b001) begin
         $display("FAIL rd_grant got=%b want=001", req_ready);
         nbad++;
      end
      tick();
      req_valid = 3'b000;
      ntot++;
      if (rsp_valid !== 3'b001 || rsp_rdata !== 4'hA) begin
         $display("FAIL rd_rsp got=%b/%h want=001/a", rsp_valid, rsp_rdata);
         nbad++;
      end
      tick();
      ntot++;
      if (rsp_valid !== 3'b000) begin
         $display("FAIL rd_pulse got=%b want=000", rsp_valid);
         nbad++;
      end
   endtask

   task automatic test_raw();
      req_valid = 3'b001;
      req_rw    = 3'b000;
      req_addr[0 +: 4]  = 4'd3;
      req_wdata[0 +: 4] = 4'h6;
      tick();
      tick();
      req_rw = 3'b001;
      tick();
      req_valid = 3'b000;
      ntot++;
      if (rsp_valid !== 3'b001 || rsp_rdata !== 4'h6) begin
         $display("FAIL raw got=%b/%h want=001/6", rsp_valid, rsp_rdata);
         nbad++;
      end
      tick();
      tick();
   endtask

   task automatic test_all_three();
      int         exp_o [8] = '{0, 0, 1, 1, 2, 2, 0, 0};
      logic [3:0] dch   [3] = '{4'hA, 4'h6, 4'hA};
      logic [2:0] oh;
      logic [2:0] poh;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      req_valid = 3'b111;
      req_rw    = 3'b111;
      req_addr  = {4'd5, 4'd3, 4'd5};
      tick();
      for (int i = 0; i < 8; i++) begin
         oh = 3'b001 << exp_o[i];
         ntot++;
         if (grant_id !== 2'(exp_o[i]) || req_ready !== oh || busy !== 1'b1) begin
            $display("FAIL rr_seq[%0d] got=%0d/%b want=%0d/%b",
                     i, grant_id, req_ready, exp_o[i], oh);
            nbad++;
         end
         if (i > 0) begin
            poh = 3'b001 << exp_o[i-1];
            ntot++;
            if (rsp_valid !== poh || rsp_rdata !== dch[exp_o[i-1]]) begin
               $display("FAIL rr_rsp[%0d] got=%b/%h want=%b/%h",
                        i, rsp_valid, rsp_rdata, poh, dch[exp_o[i-1]]);
               nbad++;
            end
         end
         tick();
      end
      req_valid = 3'b000;
      tick();
      ntot++;
      if (busy !== 1'b0) begin
         $display("FAIL rr_idle got=%b want=0", busy);
         nbad++;
      end
   endtask

   task automatic test_burst_alone();
      req_valid = 3'b100;
      req_rw    = 3'b000;
      req_addr[8 +: 4]  = 4'd8;
      req_wdata[8 +: 4] = 4'd1;
      tick();
      for (int k = 0; k < 5; k++) begin
         ntot++;
         if (req_ready !== 3'b100 || grant_id !== 2'd2) begin
            $display("FAIL burst[%0d] got=%b/%0d want=100/2",
                     k, req_ready, grant_id);
            nbad++;
         end
         tick();
         req_addr[8 +: 4]  = 4'(8 + k + 1);
         req_wdata[8 +: 4] = 4'(k + 2);
      end
      req_rw = 3'b100;
      req_addr[8 +: 4] = 4'd10;
      ntot++;
      if (req_ready !== 3'b100) begin
         $display("FAIL burst_hold got=%b want=100", req_ready);
         nbad++;
      end
      tick();
      req_valid = 3'b000;
      ntot++;
      if (rsp_valid !== 3'b100 || rsp_rdata !== 4'h3) begin
         $display("FAIL burst_rd got=%b/%h want=100/3", rsp_valid, rsp_rdata);
         nbad++;
      end
      tick();
   endtask

   task automatic test_drop();
      req_valid = 3'b011;
      req_rw    = 3'b011;
      req_addr[0 +: 4] = 4'd5;
      req_addr[4 +: 4] = 4'd3;
      tick();
      ntot++;
      if (req_ready !== 3'b001) begin
         $display("FAIL drop_grant got=%b want=001", req_ready);
         nbad++;
      end
      tick();
      req_valid = 3'b010;
      tick();
      ntot++;
      if (req_ready !== 3'b010 || grant_id !== 2'd1) begin
         $display("FAIL drop_hand got=%b/%0d want=010/1", req_ready, grant_id);
         nbad++;
      end
      ntot++;
      if (dut.rr_ptr_q !== 2'd1) begin
         $display("FAIL drop_ptr got=%0d want=1", dut.rr_ptr_q);
         nbad++;
      end
      tick();
      req_valid = 3'b000;
      ntot++;
      if (rsp_valid !== 3'b010 || rsp_rdata !== 4'h6) begin
         $display("FAIL drop_rd got=%b/%h want=010/6", rsp_valid, rsp_rdata);
         nbad++;
      end
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      req_valid = 3'b010;
      req_rw    = 3'b010;
      req_addr[4 +: 4] = 4'd5;
      tick();
      tick();
      rst = 1'b0;
      req_valid = 3'b000;
      #1;
      ntot++;
      if (rsp_valid !== 3'b000 || busy !== 1'b0 || req_ready !== 3'b000) begin
         $display("FAIL rst_mid got=%b/%b/%b want=000/0/000",
                  rsp_valid, busy, req_ready);
         nbad++;
      end
      ntot++;
      if (dut.rr_ptr_q !== 2'd0 || grant_id !== 2'd0) begin
         $display("FAIL rst_ptr got=%0d/%0d want=0/0", dut.rr_ptr_q, grant_id);
         nbad++;
      end
      tick();
      rst = 1'b1;
      tick();
      ntot++;
      if (rsp_valid !== 3'b000 || busy !== 1'b0) begin
         $display("FAIL rst_after got=%b/%b want=000/0", rsp_valid, busy);
         nbad++;
      end
   endtask

   initial begin
      clk       = 1'b0;
      rst       = 1'b0;
      req_valid = '0;
      req_rw    = '0;
      req_addr  = '0;
      req_wdata = '0;
      ntot      = 0;
      nbad      = 0;
      test_reset();
      test_write();
      test_read();
      test_raw();
      test_all_three();
      test_burst_alone();
      test_drop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", ntot, nbad);
      $finish;
   end

endmodule
